// File: rtl/display_shift_ctrl.sv
// display_shift_ctrl: walks the segment mux over every digit and shifts each
// 7-segment pattern plus decimal point into a 74HC595-style chain, latching once per frame.
module display_shift_ctrl #(
    parameter int NUM_DIGITS     = 6,
    parameter int CLK_DIV        = 2,
    parameter bit SEG_ACTIVE_LOW = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_start,
    input  logic [6:0]            i_led,
    input  logic [NUM_DIGITS-1:0] i_dp_mask,
    output logic [2:0]            o_segment_select,
    output logic                  o_serial_data,
    output logic                  o_serial_clk,
    output logic                  o_serial_latch,
    output logic                  o_busy,
    output logic                  o_done
);
    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SELECT  = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_SHIFT   = 3'd3;
    localparam logic [2:0] S_LATCH   = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]    r_state;
    logic [2:0]    r_digit;
    logic [2:0]    r_sel;
    logic [2:0]    r_bit;
    logic [CW-1:0] r_cnt;
    logic [7:0]    r_shift;
    logic          r_data;
    logic          r_sclk;
    logic          r_latch;
    logic          r_busy;
    logic          r_done;
    logic [7:0]    w_byte;
    logic          w_div_end;

    assign w_byte    = {i_dp_mask[r_digit], i_led} ^ {8{SEG_ACTIVE_LOW}};
    assign w_div_end = r_cnt == CW'(CLK_DIV - 1);

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state <= S_IDLE;
            r_digit <= 3'd0;
            r_sel   <= 3'h7;
            r_bit   <= 3'd0;
            r_cnt   <= '0;
            r_shift <= 8'd0;
            r_data  <= 1'b0;
            r_sclk  <= 1'b0;
            r_latch <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (i_start) begin
                    r_state <= S_SELECT;
                    r_digit <= 3'(NUM_DIGITS - 1);
                    r_sel   <= 3'(NUM_DIGITS - 1);
                    r_busy  <= 1'b1;
                end
                S_SELECT: r_state <= S_CAPTURE;
                // The mux output now reflects the digit selected last cycle.
                S_CAPTURE: begin
                    r_shift <= w_byte;
                    r_data  <= w_byte[7];
                    r_bit   <= 3'd0;
                    r_cnt   <= '0;
                    r_state <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                    if (w_div_end && !r_sclk) begin
                        r_sclk <= 1'b1;
                    end else if (w_div_end) begin
                        r_sclk <= 1'b0;
                        if (r_bit == 3'd7) begin
                            r_data <= 1'b0;
                            if (r_digit != 3'd0) begin
                                r_digit <= r_digit - 3'd1;
                                r_sel   <= r_digit - 3'd1;
                                r_state <= S_SELECT;
                            end else begin
                                r_sel   <= 3'h7;
                                r_latch <= 1'b1;
                                r_state <= S_LATCH;
                            end
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {r_shift[6:0], 1'b0};
                            r_data  <= r_shift[6];
                        end
                    end
                end
                S_LATCH: begin
                    r_cnt <= w_div_end ? '0 : r_cnt + 1'b1;
                    if (w_div_end) begin
                        r_latch <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_segment_select = r_sel;
    assign o_serial_data    = r_data;
    assign o_serial_clk     = r_sclk;
    assign o_serial_latch   = r_latch;
    assign o_busy           = r_busy;
    assign o_done           = r_done;
endmodule
